// File: rtl/serial_cubestate_rx.sv
// Purpose: UART (8N1) receiver that assembles sync + 21 data bytes + XOR checksum into a 162-bit cube state.
// Latency: cubestate/state_valid update one cycle after the checksum byte's stop-bit sample.
// Backpressure: none; the serial line cannot be stalled, so aborts (framing/timeout) drop the packet.
module serial_cubestate_rx #(
    parameter int          CLKS_PER_BIT = 217,
    parameter int          TIMEOUT_CLKS = 250000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic           clock_25mhz,
    input  logic           reset,
    input  logic           rx_pin,
    output logic [161:0]   cubestate,
    output logic           state_valid,
    output logic           chk_error,
    output logic           frame_error,
    output logic           busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int TMR_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam int DATA_BYTES = 21;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {PKT_WAIT_SYNC, PKT_RECV_DATA, PKT_RECV_CHK} pkt_state_t;

    // Synchronizer and edge-detect history (idle line is high)
    logic sync1_q, sync2_q, rx_prev_q;
    logic rx_s;

    // Byte receiver state
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q,  clk_cnt_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [7:0]       data_q,     data_d;
    logic             byte_done;
    logic             stop_bad;

    // Inter-byte timer
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout;

    // Packet assembly state
    pkt_state_t       pkt_q,   pkt_d;
    logic [4:0]       cnt_q,   cnt_d;
    logic [167:0]     shift_q, shift_d;
    logic [7:0]       xor_q,   xor_d;
    logic [161:0]     cube_q,  cube_d;
    logic             busy_q,  busy_d;
    logic             sv_q,    sv_d;
    logic             ce_q,    ce_d;
    logic             fe_q,    fe_d;

    assign rx_s = sync2_q;

    // Inter-byte timer: runs only while a packet is open and the line is between bytes
    always_comb begin
        tmr_d   = '0;
        timeout = 1'b0;
        if (busy_q && (rx_state_q == RX_IDLE)) begin
            if (tmr_q == TMR_W'(TIMEOUT_CLKS - 1)) begin
                timeout = 1'b1;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
    end

    // Byte receiver: start-bit qualify at half bit, then sample each bit at its centre
    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (rx_prev_q && !rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                if (clk_cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    clk_cnt_d  = '0;
                    // A high line at mid start bit is a glitch, not a byte
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    data_d    = {rx_s, data_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s) byte_done = 1'b1;
                    else      stop_bad  = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        if (timeout) rx_state_d = RX_IDLE;
    end

    // Packet FSM: sync hunt, 21 data bytes with running XOR, then checksum compare
    always_comb begin
        pkt_d   = pkt_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        xor_d   = xor_q;
        cube_d  = cube_q;
        busy_d  = busy_q;
        sv_d    = 1'b0;
        ce_d    = 1'b0;
        fe_d    = 1'b0;
        if (stop_bad || timeout) begin
            fe_d   = 1'b1;
            busy_d = 1'b0;
            pkt_d  = PKT_WAIT_SYNC;
        end else if (byte_done) begin
            case (pkt_q)
                PKT_WAIT_SYNC: begin
                    if (data_q == SYNC_BYTE) begin
                        busy_d = 1'b1;
                        cnt_d  = '0;
                        xor_d  = '0;
                        pkt_d  = PKT_RECV_DATA;
                    end
                end
                PKT_RECV_DATA: begin
                    // Sync-valued bytes land here as plain data; no resync mid-packet
                    shift_d = {shift_q[159:0], data_q};
                    xor_d   = xor_q ^ data_q;
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'(DATA_BYTES - 1)) pkt_d = PKT_RECV_CHK;
                end
                PKT_RECV_CHK: begin
                    if (data_q == xor_q) begin
                        cube_d = shift_q[161:0];
                        sv_d   = 1'b1;
                    end else begin
                        ce_d = 1'b1;
                    end
                    busy_d = 1'b0;
                    pkt_d  = PKT_WAIT_SYNC;
                end
                default: pkt_d = PKT_WAIT_SYNC;
            endcase
        end
    end

    // State registers; reset clears everything and drops any partial packet silently
    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            tmr_q      <= '0;
            pkt_q      <= PKT_WAIT_SYNC;
            cnt_q      <= '0;
            shift_q    <= '0;
            xor_q      <= '0;
            cube_q     <= '0;
            busy_q     <= 1'b0;
            sv_q       <= 1'b0;
            ce_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            sync1_q    <= rx_pin;
            sync2_q    <= sync1_q;
            rx_prev_q  <= rx_s;
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            tmr_q      <= tmr_d;
            pkt_q      <= pkt_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            xor_q      <= xor_d;
            cube_q     <= cube_d;
            busy_q     <= busy_d;
            sv_q       <= sv_d;
            ce_q       <= ce_d;
            fe_q       <= fe_d;
        end
    end

    assign cubestate   = cube_q;
    assign state_valid = sv_q;
    assign chk_error   = ce_q;
    assign frame_error = fe_q;
    assign busy        = busy_q;

endmodule

// File: doc/serial_cubestate_rx.md
SERIAL_CUBESTATE_RX -- requirements
Module: serial_cubestate_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, is the number of clock_25mhz cycles per UART bit (115200 baud).
REQ-002 Parameter TIMEOUT_CLKS, default 250000, is the maximum idle clock count between bytes inside a packet (10 ms).
REQ-003 Parameter SYNC_BYTE, default 8'hA5, is the packet start marker.
REQ-004 clock_25mhz  input  1  system clock; reset reset, synchronous, active-high; clock clock_25mhz.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 rx_pin  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 cubestate  output  162  last accepted cube state.
REQ-008 state_valid  output  1  one-cycle pulse when cubestate is updated.
REQ-009 chk_error  output  1  one-cycle pulse on checksum mismatch.
REQ-010 frame_error  output  1  one-cycle pulse on a bad stop bit or an inter-byte timeout.
REQ-011 busy  output  1  high from sync byte accepted until packet end or abort.

Function
REQ-012 rx_pin shall pass through a two-flop synchronizer before any use; all later references mean the synchronized signal.
REQ-013 Byte receiver states: IDLE, START, DATA, STOP.
- IDLE to START on a synchronized high-to-low transition.
REQ-014 START: wait CLKS_PER_BIT/2 cycles (integer division), then resample.
- Low: go to DATA.
- High: false start, return to IDLE, no pulse.
REQ-015 DATA: sample 8 bits, one every CLKS_PER_BIT cycles, LSB first, then go to STOP.
REQ-016 STOP: sample after CLKS_PER_BIT cycles.
- High: byte_done strobe for one cycle, return to IDLE.
- Low: frame_error pulse, byte discarded, packet abort.
REQ-017 Packet FSM states: WAIT_SYNC, RECV_DATA, RECV_CHK.
REQ-018 WAIT_SYNC: a byte equal to SYNC_BYTE sets busy=1, clears the byte counter and the running XOR, and moves to RECV_DATA; any other byte is ignored.
REQ-019 RECV_DATA: accept exactly 21 bytes into a 168-bit shift register, first byte in bits [167:160]; the running XOR covers each byte; after the 21st byte, go to RECV_CHK.
REQ-020 SYNC_BYTE values received in RECV_DATA or RECV_CHK shall be treated as ordinary data, never as a resync.
REQ-021 RECV_CHK, received byte equal to the running XOR:
- cubestate <= shift[161:0] and state_valid=1, both in the cycle after the checksum stop-bit sample.
- bits [167:162] discarded.
- busy=0, go to WAIT_SYNC.
REQ-022 RECV_CHK, checksum mismatch: chk_error one-cycle pulse, cubestate unchanged, busy=0, go to WAIT_SYNC.
REQ-023 Inter-byte timer: counts cycles while busy=1 and the byte receiver is IDLE; clears on each byte_done.
- Reaching TIMEOUT_CLKS: frame_error pulse, busy=0, WAIT_SYNC, cubestate unchanged.
REQ-024 Any abort (framing error or timeout) returns the packet FSM to WAIT_SYNC, and the byte receiver to IDLE, in the same cycle.
REQ-025 state_valid, chk_error and frame_error shall never be asserted in the same cycle.
REQ-026 cubestate shall change only on a state_valid cycle.

Reset
REQ-027 While reset=1, the following outputs and registers shall be zero: cubestate, state_valid, chk_error, frame_error, busy, all counters, the shift register and the running XOR.
- Both FSMs go to IDLE / WAIT_SYNC, synchronizer flops set to 1.
REQ-028 Reset asserted mid-packet discards the partial packet with no error pulse; reset has priority over all other events.

Verification
REQ-029 Send A5, 21 bytes 00 01 .. 14, checksum 14 at 115200 baud -> one state_valid pulse; cubestate = the 162 LSBs of 0x000102..14; busy low after the pulse.
REQ-030 Same packet with checksum 15 -> chk_error pulse, no state_valid, cubestate unchanged from the prior value.
REQ-031 A5 followed by 10 bytes, then 12 ms idle -> frame_error pulse about 10 ms after the 10th byte; busy=0; a complete valid packet sent afterwards is accepted.
REQ-032 Stop bit driven low on data byte 5 -> frame_error pulse, abort; bytes 3C 7E before A5 are ignored.
REQ-033 A 2-cycle low glitch on idle rx_pin -> no byte_done and no pulses; reset asserted at data byte 12 -> all outputs 0, no pulse.
REQ-034 Packet whose data contains A5 at byte 3 -> accepted as data; state_valid with the correct value.
